// File: rtl/mips_debug_host.sv
// Host-side driver for the MIPS core debug port: turns a run/halt/step/dump
// command stream into debug_en/debug_step/debug_addr activity and streams dumped registers as bytes.
module mips_debug_host #(
  parameter int SCAN_WORDS   = 64,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [7:0]  out_data_o,
  output logic        busy_o,
  output logic        debug_en_o,
  output logic        debug_step_o,
  output logic [6:0]  debug_addr_o,
  input  logic [31:0] debug_data_i,
  output logic [2:0]  dbg_state_o
);

  // Handshakes: a command transfers when cmd_valid_i && cmd_ready_o at a rising
  // edge; a byte transfers when out_valid_o && out_ready_i. Once raised,
  // out_valid_o and out_data_o hold until the byte transfers, and out_valid_o
  // never depends on out_ready_i in the same cycle.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PULSE   = 3'd1,
    S_SETTLE  = 3'd2,
    S_CAPTURE = 3'd3,
    S_EMIT    = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  localparam logic [1:0] OP_RUN  = 2'b00;
  localparam logic [1:0] OP_HALT = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_DUMP = 2'b11;

  localparam logic [6:0] LAST_ADDR   = 7'(SCAN_WORDS - 1);
  localparam logic [2:0] SETTLE_LAST = 3'((READ_LATENCY == 0) ? 0 : READ_LATENCY - 1);
  // With zero read latency the address change is usable at once, so skip SETTLE.
  localparam state_e     AFTER_ADDR  = (READ_LATENCY == 0) ? S_CAPTURE : S_SETTLE;

  state_e      state_q;
  logic        cmd_ready_q;
  logic        busy_q;
  logic        out_valid_q;
  logic [7:0]  out_data_q;
  logic        debug_en_q;
  logic        debug_step_q;
  logic [6:0]  debug_addr_q;
  logic        saved_en_q;
  logic [2:0]  settle_cnt_q;
  logic [2:0]  byte_idx_q;
  logic [31:0] shadow_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      debug_en_q   <= 1'b1;
      debug_step_q <= 1'b0;
      debug_addr_q <= 7'd0;
      saved_en_q   <= 1'b1;
      settle_cnt_q <= 3'd0;
      byte_idx_q   <= 3'd0;
      shadow_q     <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            case (cmd_op_i)
              OP_RUN:  debug_en_q <= 1'b0;
              OP_HALT: debug_en_q <= 1'b1;
              OP_STEP: begin
                // A step only means something to a halted core, so halt it too.
                debug_en_q   <= 1'b1;
                debug_step_q <= 1'b1;
                busy_q       <= 1'b1;
                cmd_ready_q  <= 1'b0;
                state_q      <= S_PULSE;
              end
              OP_DUMP: begin
                saved_en_q   <= debug_en_q;
                debug_en_q   <= 1'b1;
                debug_addr_q <= 7'd0;
                settle_cnt_q <= 3'd0;
                busy_q       <= 1'b1;
                cmd_ready_q  <= 1'b0;
                state_q      <= AFTER_ADDR;
              end
              default: ;
            endcase
          end
        end

        S_PULSE: begin
          debug_step_q <= 1'b0;
          busy_q       <= 1'b0;
          cmd_ready_q  <= 1'b1;
          state_q      <= S_IDLE;
        end

        S_SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            state_q <= S_CAPTURE;
          end else begin
            settle_cnt_q <= settle_cnt_q + 3'd1;
          end
        end

        S_CAPTURE: begin
          shadow_q    <= debug_data_i;
          byte_idx_q  <= 3'd0;
          out_data_q  <= {1'b0, debug_addr_q};
          out_valid_q <= 1'b1;
          state_q     <= S_EMIT;
        end

        S_EMIT: begin
          if (out_ready_i) begin
            if (byte_idx_q == 3'd4) begin
              out_valid_q <= 1'b0;
              out_data_q  <= 8'h00;
              if (debug_addr_q == LAST_ADDR) begin
                state_q <= S_DONE;
              end else begin
                debug_addr_q <= debug_addr_q + 7'd1;
                settle_cnt_q <= 3'd0;
                state_q      <= AFTER_ADDR;
              end
            end else begin
              // Shadow shifts left so its top byte is always the next to send.
              out_data_q <= shadow_q[31:24];
              shadow_q   <= {shadow_q[23:0], 8'h00};
              byte_idx_q <= byte_idx_q + 3'd1;
            end
          end
        end

        S_DONE: begin
          debug_en_q   <= saved_en_q;
          debug_addr_q <= 7'd0;
          busy_q       <= 1'b0;
          cmd_ready_q  <= 1'b1;
          state_q      <= S_IDLE;
        end

        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign busy_o       = busy_q;
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign debug_en_o   = debug_en_q;
  assign debug_step_o = debug_step_q;
  assign debug_addr_o = debug_addr_q;
  assign dbg_state_o  = state_q;

endmodule

// File: doc/mips_debug_host.md
# mips_debug_host

Host-side controller for the MIPS core's debug port: it drives `debug_en`, `debug_step` and `debug_addr`, and reads `debug_data`. It takes a command stream (run, halt, single-step, dump) and returns the core's debug registers as a byte stream over a valid/ready handshake. It sits between the core's debug port and a byte-oriented link such as a UART transmitter. It replaces hand-driven debug inputs in system-level benches and on the board.

## Interface
Parameters:
- `SCAN_WORDS`, default 64: number of debug addresses swept by DUMP (addresses 0..SCAN_WORDS-1); legal range 1..128.
- `READ_LATENCY`, default 1: clk cycles from a `debug_addr` change until `debug_data` is valid; legal range 0..7.

Ports:
- `clk`  in  1  system clock; everything is rising-edge.
- `rst`  in  1  reset. One clock domain; reset is synchronous and active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when both `cmd_valid` and `cmd_ready` are high at a clk edge.
- `cmd_op`  in  2  command opcode:
  - 00 = RUN
  - 01 = HALT
  - 10 = STEP
  - 11 = DUMP
- `out_valid`  out  1  `out_data` holds a byte.
- `out_ready`  in  1  downstream accepts the byte.
- `out_data`  out  8  stream byte.
- `busy`  out  1  high while a STEP or DUMP is in progress.
- `debug_en`  out  1  to core: 1 = halted in debug mode, 0 = free run.
- `debug_step`  out  1  to core: one-cycle step pulse. Meaningful only while `debug_en`=1.
- `debug_addr`  out  7  to core: debug register select.
- `debug_data`  in  32  from core: selected register value.

## Operation
- Reset values:
  - `debug_en`=1 (core halted), `debug_step`=0, `debug_addr`=0.
  - `cmd_ready`=1, `out_valid`=0, `out_data`=0, `busy`=0.
  - FSM in IDLE; saved run-mode bit = halted.
- States and transitions:
  - IDLE: `cmd_ready`=1.
    - RUN: `debug_en`←0.
    - HALT: `debug_en`←1.
    - STEP: go to PULSE.
    - DUMP: save current `debug_en`, set `debug_en`←1, set `debug_addr`←0, go to SETTLE.
  - PULSE: `debug_step`=1 for exactly this one cycle, then back to IDLE. If `debug_en`=0 when STEP is accepted, `debug_en` is forced to 1 in the same cycle as PULSE and stays 1.
  - SETTLE: wait READ_LATENCY cycles, then go to CAPTURE. With READ_LATENCY=0, pass straight through with no wait cycle.
  - CAPTURE: latch `debug_data` into a 32-bit shadow register, set byte index←0, go to EMIT.
  - EMIT: present 5 bytes in order:
    - byte 0: {1'b0, `debug_addr`}
    - bytes 1-4: shadow[31:24], shadow[23:16], shadow[15:8], shadow[7:0]
    - Advance to the next byte only on `out_valid`&&`out_ready`.
    - After byte 4 is accepted: if `debug_addr`==SCAN_WORDS-1, go to DONE; otherwise increment `debug_addr` and go to SETTLE.
  - DONE: restore the saved `debug_en`, `debug_addr`←0, go to IDLE.
- `busy`=1 in PULSE, SETTLE, CAPTURE, EMIT and DONE; 0 in IDLE.
- `cmd_ready`=0 whenever `busy`=1. Commands arriving while busy are not accepted and stay pending on the input.
- `debug_data` is sampled only in CAPTURE. Changes during EMIT do not affect the bytes being sent.
- `debug_addr` never exceeds SCAN_WORDS-1. The 7-bit counter does not wrap during a dump.

## Timing
- RUN/HALT: `debug_en` takes its new value in the cycle after acceptance. `cmd_ready` stays 1, so back-to-back commands are allowed.
- STEP: `debug_step`=1 in cycle N+1 after acceptance at edge N. `cmd_ready`=1 again in cycle N+2. Minimum spacing between steps is 2 cycles.
- DUMP: `debug_addr`=0 in cycle N+1. First `out_valid` in cycle N+2+READ_LATENCY.
  - With `out_ready` tied high, each word takes 5+READ_LATENCY+1 cycles.
  - After the final byte is accepted: DONE is the next cycle, and `cmd_ready`=1 the cycle after that.
- Stream rules:
  - Once raised, `out_valid` stays high and `out_data` stays stable until accepted.
  - `out_valid` never depends combinationally on `out_ready`.
- `rst` mid-operation: on the next edge, all outputs return to their reset values, the partial byte stream is abandoned, and the core is left halted (`debug_en`=1).

## Test plan
- Reset: hold `rst` for 2 cycles → all outputs at reset values; `cmd_ready`=1.
- RUN then HALT on consecutive cycles → `debug_en` reads 0, then 1, one cycle after each acceptance; `busy` stays 0.
- STEP ×3 with `cmd_valid` held high → exactly three one-cycle `debug_step` pulses, spaced 2 cycles apart.
- DUMP with SCAN_WORDS=4, READ_LATENCY=1, stub returning `debug_data`={25'h0, addr}+32'hA5A50000, `out_ready`=1 → 20 bytes: 00 A5 A5 00 00, 01 A5 A5 00 01, … 03 A5 A5 00 03; first byte in cycle N+3; `debug_en` restored to its prior value (test both 0 and 1).
- DUMP with random `out_ready` stalls and `debug_data` changing every cycle → each word equals the value presented at its CAPTURE cycle; no byte is dropped or repeated; `out_data` is stable while stalled.
- Assert `rst` during byte 2 of word 1 → next cycle `out_valid`=0, `busy`=0, `debug_en`=1, `debug_addr`=0; a following DUMP restarts from address 0.
